// File: rtl/reg4_tick_sequencer.sv
// Synchronises tick_src, edge-detects it and steps a W-bit register per tick while in RUN; tick_pulse
// SYNC_STAGES-1 cycles after tick_src is sampled high, data one later; load_ready drops in RUN. Option: SEQ_STEP_LIMIT_EN.
module reg4_tick_sequencer #(
   parameter int unsigned    W           = 4,
   parameter logic [W-1:0]   INIT        = W'(4'b0001),
   parameter int unsigned    SYNC_STAGES = 2
) (
   input  logic         clk_in,
   input  logic         rstn,
   input  logic         tick_src,
   input  logic         start,
   input  logic         stop,
   input  logic [1:0]   mode,
   input  logic         load_valid,
   input  logic [W-1:0] load_data,
   output logic         load_ready,
   output logic [W-1:0] data,
   output logic         running,
   output logic         tick_pulse
`ifdef SEQ_STEP_LIMIT_EN
   ,
   input  logic [7:0]   step_limit,
   output logic         done
`endif
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   localparam logic [1:0] MODE_ROTL = 2'b01;
   localparam logic [1:0] MODE_ROTR = 2'b10;
   localparam logic [1:0] MODE_INC  = 2'b11;

   state_t                 state_q;
   logic [W-1:0]           data_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   tick;

   // Both operands are flops, so the pulse is clean and exactly one cycle wide per rising edge.
   assign tick       = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign tick_pulse = tick;
   assign data       = data_q;

   function automatic logic [W-1:0] step_fn(input logic [1:0] m, input logic [W-1:0] d);
      case (m)
         MODE_ROTL: step_fn = {d[W-2:0], d[W-1]};
         MODE_ROTR: step_fn = {d[0], d[W-1:1]};
         MODE_INC:  step_fn = d + W'(1);
         default:   step_fn = d;
      endcase
   endfunction

`ifdef SEQ_STEP_LIMIT_EN
   logic [7:0] step_cnt_q;
   logic [7:0] step_cnt_nxt;
   logic       limit_hit;

   assign step_cnt_nxt = step_cnt_q + 8'd1;
   assign limit_hit    = (step_limit != 8'd0) && (step_cnt_nxt == step_limit);
`else
   logic       limit_hit;

   assign limit_hit = 1'b0;
`endif

   always_ff @(posedge clk_in) begin
      if (!rstn) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         state_q    <= ST_IDLE;
         data_q     <= INIT;
         running    <= 1'b0;
         load_ready <= 1'b1;
`ifdef SEQ_STEP_LIMIT_EN
         step_cnt_q <= 8'd0;
         done       <= 1'b0;
`endif
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tick_src};
         prev_q <= sync_q[SYNC_STAGES-1];
`ifdef SEQ_STEP_LIMIT_EN
         done   <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               // load_ready is high throughout IDLE, so a valid request always transfers here
               if (load_valid) begin
                  data_q <= load_data;
               end
               if (start && !stop) begin
                  state_q    <= ST_RUN;
                  running    <= 1'b1;
                  load_ready <= 1'b0;
`ifdef SEQ_STEP_LIMIT_EN
                  step_cnt_q <= 8'd0;
`endif
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_q    <= ST_IDLE;
                  running    <= 1'b0;
                  load_ready <= 1'b1;
               end else if (tick) begin
                  data_q <= step_fn(mode, data_q);
`ifdef SEQ_STEP_LIMIT_EN
                  step_cnt_q <= step_cnt_nxt;
`endif
                  if (limit_hit) begin
                     state_q    <= ST_IDLE;
                     running    <= 1'b0;
                     load_ready <= 1'b1;
`ifdef SEQ_STEP_LIMIT_EN
                     done       <= 1'b1;
`endif
                  end
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               running    <= 1'b0;
               load_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg4_tick_sequencer.sv
// Bench for reg4_tick_sequencer: vector table, directed corner sequences, then random traffic against a reference model.
module tb_reg4_tick_sequencer;

   localparam int S = 2;

   logic       clk_in = 1'b0;
   logic       rstn, tick_src, start, stop, load_valid;
   logic [1:0] mode;
   logic [3:0] load_data;
   logic       load_ready, running, tick_pulse;
   logic [3:0] data;
`ifdef SEQ_STEP_LIMIT_EN
   logic [7:0] step_limit;
   logic       done;
`endif

   reg4_tick_sequencer dut (
      .clk_in     (clk_in),
      .rstn       (rstn),
      .tick_src   (tick_src),
      .start      (start),
      .stop       (stop),
      .mode       (mode),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .data       (data),
      .running    (running),
      .tick_pulse (tick_pulse)
`ifdef SEQ_STEP_LIMIT_EN
      ,
      .step_limit (step_limit),
      .done       (done)
`endif
   );

   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state
   int m_data = 1;
   bit m_run  = 0;
   bit m_tp   = 0;
   bit m_done = 0;
   int m_cnt  = 0;
   bit hist[$];   // tick_src samples, newest first

   typedef struct {
      logic       rstn, src, start, stop;
      logic [1:0] mode;
      logic       lv;
      logic [3:0] ld;
      logic [3:0] e_data;
      logic       e_run, e_rdy, e_tp;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int ref_step(input logic [1:0] md, input int d);
      case (md)
         2'd1:    return (d * 2) % 16 + d / 8;
         2'd2:    return d / 2 + (d % 2) * 8;
         2'd3:    return (d + 1) % 16;
         default: return d;
      endcase
   endfunction

   task automatic model_reset();
      m_data = 1; m_run = 0; m_cnt = 0; m_done = 0;
      hist = {};
      for (int i = 0; i <= S; i++) hist.push_front(1'b0);
   endtask

   // One clock: model follows the edge using the inputs present at it, then DUT is compared.
   task automatic cycle();
      bit tk;
      tk = m_tp;
      @(posedge clk_in);
      if (!rstn) begin
         model_reset();
      end else begin
         m_done = 0;
         if (!m_run) begin
            if (load_valid) m_data = load_data;
            if (start && !stop) begin m_run = 1; m_cnt = 0; end
         end else if (stop) begin
            m_run = 0;
         end else if (tk) begin
            m_data = ref_step(mode, m_data);
            m_cnt  = (m_cnt + 1) % 256;
`ifdef SEQ_STEP_LIMIT_EN
            if (step_limit != 0 && m_cnt == int'(step_limit)) begin
               m_run = 0; m_done = 1;
            end
`endif
         end
         hist.push_front(tick_src);
         void'(hist.pop_back());
      end
      // a tick is a sample that is high S-1 cycles back while the one before it was low
      m_tp = hist[S-1] && !hist[S];
      #1;
      chk("model data", data, 8'(m_data));
      chk("model running", running, m_run);
      chk("model load_ready", load_ready, !m_run);
      chk("model tick_pulse", tick_pulse, m_tp);
`ifdef SEQ_STEP_LIMIT_EN
      chk("model done", done, m_done);
`endif
   endtask

   task automatic add(input logic r, input logic s, input logic st, input logic sp, input logic [1:0] md,
                      input logic lv, input logic [3:0] ld, input logic [3:0] ed, input logic er,
                      input logic ery, input logic etp);
      vec_t v;
      v.rstn = r; v.src = s; v.start = st; v.stop = sp; v.mode = md; v.lv = lv; v.ld = ld;
      v.e_data = ed; v.e_run = er; v.e_rdy = ery; v.e_tp = etp;
      tbl.push_back(v);
   endtask

   task automatic idle_inputs();
      start = 0; stop = 0; load_valid = 0; load_data = 0;
   endtask

   task automatic do_tick();
      tick_src = 1; cycle(); cycle();
      tick_src = 0; cycle(); cycle();
   endtask

   initial begin
      logic [3:0] seq1[5];
      logic [3:0] seq2[4];
      vec_t v;
      int tp_cnt;

      rstn = 0; tick_src = 0; mode = 0;
      idle_inputs();
`ifdef SEQ_STEP_LIMIT_EN
      step_limit = 0;
`endif
      model_reset();

      // rotate-left through four ticks, then load+start with increment and wrap
      seq1 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
      seq2 = '{4'hE, 4'hF, 4'h0, 4'h1};
      add(0, 0, 0, 0, 2'b01, 0, 4'h0, 4'h1, 0, 1, 0);
      add(1, 0, 1, 0, 2'b01, 0, 4'h0, 4'h1, 1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         add(1, 1, 0, 0, 2'b01, 0, 4'h0, seq1[k],   1, 0, 0);
         add(1, 1, 0, 0, 2'b01, 0, 4'h0, seq1[k],   1, 0, 1);
         add(1, 0, 0, 0, 2'b01, 0, 4'h0, seq1[k+1], 1, 0, 0);
         add(1, 0, 0, 0, 2'b01, 0, 4'h0, seq1[k+1], 1, 0, 0);
      end
      add(1, 0, 0, 1, 2'b01, 0, 4'h0, 4'h1, 0, 1, 0);
      add(1, 0, 1, 0, 2'b11, 1, 4'hE, 4'hE, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         add(1, 1, 0, 0, 2'b11, 0, 4'h0, seq2[k],   1, 0, 0);
         add(1, 1, 0, 0, 2'b11, 0, 4'h0, seq2[k],   1, 0, 1);
         add(1, 0, 0, 0, 2'b11, 0, 4'h0, seq2[k+1], 1, 0, 0);
         add(1, 0, 0, 0, 2'b11, 0, 4'h0, seq2[k+1], 1, 0, 0);
      end
      add(1, 0, 0, 1, 2'b11, 0, 4'h0, 4'h1, 0, 1, 0);

      foreach (tbl[i]) begin
         v = tbl[i];
         rstn = v.rstn; tick_src = v.src; start = v.start; stop = v.stop;
         mode = v.mode; load_valid = v.lv; load_data = v.ld;
         cycle();
         chk($sformatf("vec%0d data", i), data, v.e_data);
         chk($sformatf("vec%0d running", i), running, v.e_run);
         chk($sformatf("vec%0d load_ready", i), load_ready, v.e_rdy);
         chk($sformatf("vec%0d tick_pulse", i), tick_pulse, v.e_tp);
      end
      idle_inputs();

      // load request during RUN stalls until the FSM is back in IDLE
      mode = 2'b00; start = 1; cycle(); start = 0;
      load_valid = 1; load_data = 4'h5;
      cycle();
      chk("load in RUN ready", load_ready, 1'b0);
      chk("load in RUN data", data, 4'h1);
      stop = 1; cycle(); stop = 0;
      chk("stop with load pending running", running, 1'b0);
      chk("stop with load pending data", data, 4'h1);
      cycle();
      chk("load after stop data", data, 4'h5);
      idle_inputs();

      // start+stop together, then stop coinciding with a tick
      start = 1; stop = 1; cycle();
      chk("start+stop running", running, 1'b0);
      stop = 0; load_valid = 1; load_data = 4'h3; mode = 2'b11; cycle();
      chk("load+start data", data, 4'h3);
      chk("load+start running", running, 1'b1);
      idle_inputs();
      tick_src = 1; cycle(); cycle();
      chk("tick cycle pulse", tick_pulse, 1'b1);
      tick_src = 0; stop = 1; cycle(); stop = 0;
      chk("stop+tick data", data, 4'h3);
      chk("stop+tick running", running, 1'b0);
      cycle();

      // reset mid-RUN with a tick pending, tick_src held high across reset release
      load_valid = 1; load_data = 4'hA; start = 1; mode = 2'b01; cycle();
      idle_inputs();
      chk("pre-reset data", data, 4'hA);
      tick_src = 1; cycle(); cycle();
      rstn = 0; cycle();
      chk("reset mid-RUN data", data, 4'h1);
      chk("reset mid-RUN running", running, 1'b0);
      chk("reset mid-RUN tick_pulse", tick_pulse, 1'b0);
      cycle();
      rstn = 1;
      tp_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (tick_pulse === 1'b1) tp_cnt++;
      end
      chk("spurious tick count", 8'(tp_cnt), 8'd1);
      chk("spurious tick data", data, 4'h1);
      tick_src = 0; cycle(); cycle();

`ifdef SEQ_STEP_LIMIT_EN
      step_limit = 8'd3; mode = 2'b01; start = 1; cycle(); start = 0;
      do_tick(); do_tick();
      tick_src = 1; cycle(); cycle();
      tick_src = 0; cycle();
      chk("limit data", data, 4'h8);
      chk("limit running", running, 1'b0);
      chk("limit done", done, 1'b1);
      cycle();
      chk("limit done width", done, 1'b0);
      do_tick();
      chk("after limit data", data, 4'h8);
      step_limit = 8'd0;
`endif

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rstn       = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 3) == 0) tick_src = ~tick_src;
         start      = ($urandom_range(0, 7) == 0);
         stop       = ($urandom_range(0, 11) == 0);
         mode       = 2'($urandom_range(0, 3));
         load_valid = ($urandom_range(0, 3) == 0);
         load_data  = 4'($urandom_range(0, 15));
`ifdef SEQ_STEP_LIMIT_EN
         if ($urandom_range(0, 49) == 0) step_limit = 8'($urandom_range(0, 5));
`endif
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/reg4_tick_sequencer.md
Name: reg4_tick_sequencer

Overview:
- Downstream consumer of the prescaler's divided output.
- Samples the slow `tick_src` signal in the fast `clk_in` domain and edge-detects it into single-cycle ticks.
- On each tick, advances a W-bit register by a selectable operation: hold, rotate-left, rotate-right or increment.
- Run/idle FSM with start/stop control and a valid/ready load port; `data` drives LEDs or a downstream register.

Parameters:
- W, 4, register width in bits.
- INIT, 4'b0001, reset and idle-default value of data (W bits).
- SYNC_STAGES, 2, synchronizer flops on tick_src (legal 2..4).

Ports:
- clk_in  input  1  system clock, rising edge.
- rstn  input  1  reset, synchronous, active-low.
- tick_src  input  1  slow divided clock from the prescaler (MSB of its counter); asynchronous-ish level.
- start  input  1  request IDLE->RUN.
- stop  input  1  request RUN->IDLE.
- mode  input  2  00 hold, 01 rotate left, 10 rotate right, 11 increment.
- load_valid  input  1  load request.
- load_data  input  W  value to load.
- load_ready  output  1  load can be accepted this cycle.
- data  output  W  register contents.
- running  output  1  high while in RUN.
- tick_pulse  output  1  one-cycle pulse per detected tick_src rising edge.

Behaviour:
- Clock and reset: single clock, clk_in; rstn is synchronous and active-low.
- Reset state (rstn low at an edge):
  - data=INIT, FSM=IDLE, running=0, load_ready=1.
  - All sync flops and the edge-detect delay flop = 0, tick_pulse=0.
- Synchronizer: tick_src passes through SYNC_STAGES flops, then one delay flop `prev`.
  - tick = sync_last & ~prev; tick_pulse = tick, driven only from flops, so glitch-free.
- Latency: if tick_src is first sampled high at edge E0:
  - tick_pulse is high for exactly one cycle, following edge E(SYNC_STAGES-1).
  - data updates at edge E(SYNC_STAGES).
- One tick per tick_src rising edge regardless of its high time. A high time shorter than one clk_in period may be missed.
- FSM states:
  - IDLE: ticks ignored; data holds. start=1 and stop=0 -> RUN next edge.
  - RUN: on tick, data <= f(mode, data), with mode sampled on the tick cycle. stop=1 -> IDLE next edge.
- Mode functions:
  - Rotate left: {data[W-2:0], data[W-1]}.
  - Rotate right: {data[0], data[W-1:1]}.
  - Increment: (data+1) mod 2^W, wrapping all-ones -> 0 with no flag.
  - Hold: unchanged.
- Precedence rules:
  - start and stop together: stop wins.
  - stop and tick together in RUN: tick discarded, data unchanged.
  - start while in RUN: ignored.
- Load handshake:
  - load_ready = (state==IDLE).
  - Transfer when load_valid & load_ready: data <= load_data at that edge.
  - load_valid while in RUN: no transfer; the requester must hold load_valid/load_data until accepted.
  - Load and start in the same IDLE cycle: both take effect; data=load_data, state=RUN. A tick in that cycle is ignored.
- running is registered: equals (state==RUN).
- Reset mid-RUN: immediate return to reset values at that edge; a pending tick is lost.
- If tick_src is high across reset release, a spurious tick is produced SYNC_STAGES cycles later. The FSM is in IDLE at that point, so it has no effect.

Optional Feature:
- Macro SEQ_STEP_LIMIT_EN.
- When defined:
  - Adds port step_limit input 8 and port done output 1.
  - An 8-bit step counter clears on entry to RUN and increments on each applied tick.
  - When the applied tick makes count == step_limit (step_limit != 0), FSM -> IDLE at that same edge and done pulses high for one cycle after it.
  - step_limit=0 means unlimited.
  - done resets to 0; stop before the limit gives no done.
- When undefined: ports and counter are absent; RUN continues until stop.

Test Plan:
- Reset, mode=01, start, 4 tick_src rising edges -> data 0001->0010->0100->1000->0001; each update follows its tick_pulse by 1 cycle; tick_pulse seen 4 times.
- IDLE, load_valid=1, load_data=1110, mode=11, start same cycle; 3 ticks -> data 1110->1111->0000->0001, running=1.
- RUN, load_valid=1 with 0101 -> load_ready=0 and data unaffected; stop -> IDLE; next cycle load accepted, data=0101.
- start=stop=1 in IDLE -> remains IDLE. In RUN, stop asserted in the tick cycle with data=0011, mode=11 -> data stays 0011, running=0.
- Reset asserted mid-RUN with data=1010 -> data=0001, running=0, tick_pulse=0 at that edge; tick_src held high through reset -> one tick_pulse, data unchanged.
- SEQ_STEP_LIMIT_EN, step_limit=3, mode=01, start -> after 3rd tick data=1000, running=0, done high exactly 1 cycle; 4th tick leaves data=1000.
